// File: rtl/mult_div_unit.sv
// Multi-cycle HI/LO multiply/divide unit for the EX stage.
// Optional accumulate ops (madd/maddu/msub/msubu) built when MDU_MADD_EN is defined.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  MDUop,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        HIwrite,
  input  logic        LOwrite,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd5;
  localparam logic [3:0] OP_MADDU = 4'd6;
  localparam logic [3:0] OP_MSUB  = 4'd7;
  localparam logic [3:0] OP_MSUBU = 4'd8;
`endif

  localparam logic [3:0] MC = 4'(MULT_CYCLES);
  localparam logic [3:0] DC = 4'(DIV_CYCLES);

  typedef enum logic [0:0] {
    IDLE,
    RUN
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [3:0]  cnt;
  logic [3:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        legal;
  logic        is_div;
  logic        last;

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] sq;
  logic [31:0] sr;
  logic [63:0] res;
  logic        wr;

  assign busy = (state == RUN);
  assign HI   = hi;
  assign LO   = lo;
  assign last = (state == RUN) && (cnt == 4'd1);

  always_comb begin
    legal  = 1'b0;
    is_div = 1'b0;
    case (MDUop)
      OP_MULT, OP_MULTU: legal = 1'b1;
      OP_DIV, OP_DIVU: begin
        legal  = 1'b1;
        is_div = 1'b1;
      end
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU,
      OP_MSUB, OP_MSUBU: legal = 1'b1;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (start && legal) state_n = RUN;
      RUN:  if (cnt == 4'd1) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Signed divide via magnitudes so INT_MIN / -1 wraps cleanly.
  always_comb begin
    prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    prod_u = {32'd0, a_q} * {32'd0, b_q};
    mag_a  = a_q[31] ? -a_q : a_q;
    mag_b  = b_q[31] ? -b_q : b_q;
    uq     = mag_a / mag_b;
    ur     = mag_a % mag_b;
    sq     = (a_q[31] ^ b_q[31]) ? -uq : uq;
    sr     = a_q[31] ? -ur : ur;
  end

  always_comb begin
    res = {hi, lo};
    wr  = 1'b0;
    case (op_q)
      OP_MULT: begin
        res = prod_s;
        wr  = 1'b1;
      end
      OP_MULTU: begin
        res = prod_u;
        wr  = 1'b1;
      end
      OP_DIV: begin
        res = {sr, sq};
        wr  = (b_q != 32'd0);
      end
      OP_DIVU: begin
        res = {a_q % b_q, a_q / b_q};
        wr  = (b_q != 32'd0);
      end
`ifdef MDU_MADD_EN
      OP_MADD: begin
        res = {hi, lo} + prod_s;
        wr  = 1'b1;
      end
      OP_MADDU: begin
        res = {hi, lo} + prod_u;
        wr  = 1'b1;
      end
      OP_MSUB: begin
        res = {hi, lo} - prod_s;
        wr  = 1'b1;
      end
      OP_MSUBU: begin
        res = {hi, lo} - prod_u;
        wr  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= 4'd0;
      op_q <= 4'd0;
      a_q  <= 32'd0;
      b_q  <= 32'd0;
      hi   <= 32'd0;
      lo   <= 32'd0;
    end else if (state == IDLE) begin
      if (start) begin
        if (legal) begin
          op_q <= MDUop;
          a_q  <= A;
          b_q  <= B;
          cnt  <= is_div ? DC : MC;
        end
      end else begin
        if (HIwrite) hi <= A;
        if (LOwrite) lo <= A;
      end
    end else if (last) begin
      cnt <= 4'd0;
      if (wr) begin
        hi <= res[63:32];
        lo <= res[31:0];
      end
    end else begin
      cnt <= cnt - 4'd1;
    end
  end

endmodule
